// File: rtl/regfile_pair.sv
// regfile_pair: byte-addressable register file with register-pair access for
// the 8085 datapath (B/C, D/E, H/L plus spare slots). Two combinational byte
// read ports, one byte write port, and a pair port with 16-bit write and
// INX/DCX-style increment/decrement that reports wrap-around one cycle later.
// Optional build macro REGFILE_BYPASS_EN: read ports forward the value that
// will be committed at the next clock edge.
module regfile_pair #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned NREGS    = 8,
    parameter int unsigned AW       = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [DATASIZE-1:0]     wdata,
    input  logic [AW-1:0]           raddr_a,
    output logic [DATASIZE-1:0]     rdata_a,
    input  logic [AW-1:0]           raddr_b,
    output logic [DATASIZE-1:0]     rdata_b,
    input  logic [AW-2:0]           paddr,
    input  logic                    pwe,
    input  logic [2*DATASIZE-1:0]   pwdata,
    input  logic                    inc,
    input  logic                    dec,
    output logic [2*DATASIZE-1:0]   prdata,
    output logic                    pwrap
);

    localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
    localparam logic [AW-1:0] NPAIRS_W = AW'(NREGS / 2);

    logic [DATASIZE-1:0]   regs [NREGS];
    logic [DATASIZE-1:0]   nxt  [NREGS];
    logic [DATASIZE-1:0]   src  [NREGS];
    logic                  pwrap_nxt;
    logic                  pair_busy;
    logic [2*DATASIZE-1:0] cur_p;
    logic [2*DATASIZE-1:0] new_p;

    logic [AW-1:0] hi_idx;
    logic [AW-1:0] lo_idx;
    logic          p_ok;
    logic          w_ok;
    logic          a_ok;
    logic          b_ok;

    assign hi_idx = {paddr, 1'b0};
    assign lo_idx = {paddr, 1'b1};
    assign p_ok   = {1'b0, paddr} < NPAIRS_W;
    assign w_ok   = {1'b0, waddr} < NREGS_W;
    assign a_ok   = {1'b0, raddr_a} < NREGS_W;
    assign b_ok   = {1'b0, raddr_b} < NREGS_W;

    // Next-state arbitration: pair write beats inc/dec, any pair operation
    // beats a byte write into the same pair, other byte writes proceed.
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            nxt[i] = regs[i];
        end
        pwrap_nxt = 1'b0;
        pair_busy = 1'b0;
        cur_p     = '0;
        new_p     = '0;
        if (p_ok) begin
            cur_p = {regs[hi_idx], regs[lo_idx]};
            if (pwe) begin
                pair_busy   = 1'b1;
                nxt[hi_idx] = pwdata[2*DATASIZE-1:DATASIZE];
                nxt[lo_idx] = pwdata[DATASIZE-1:0];
            end else if (inc ^ dec) begin
                pair_busy   = 1'b1;
                new_p       = inc ? cur_p + (2*DATASIZE)'(1) : cur_p - (2*DATASIZE)'(1);
                pwrap_nxt   = inc ? (cur_p == '1) : (cur_p == '0);
                nxt[hi_idx] = new_p[2*DATASIZE-1:DATASIZE];
                nxt[lo_idx] = new_p[DATASIZE-1:0];
            end
        end
        if (we && w_ok && !(pair_busy && (waddr[AW-1:1] == paddr))) begin
            nxt[waddr] = wdata;
        end
    end

    // Read source: committed state, or forwarded next state when bypassing
    // (suppressed while reset is held so outputs read 0 immediately).
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
`ifdef REGFILE_BYPASS_EN
            src[i] = rst ? regs[i] : nxt[i];
`else
            src[i] = regs[i];
`endif
        end
    end

    // Combinational read ports; out-of-range addresses read 0.
    always_comb begin
        rdata_a = a_ok ? src[raddr_a] : '0;
        rdata_b = b_ok ? src[raddr_b] : '0;
        prdata  = p_ok ? {src[hi_idx], src[lo_idx]} : '0;
    end

    // State commit with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pwrap <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= nxt[i];
            end
            pwrap <= pwrap_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_pair.sv
// Scoreboard bench for regfile_pair: a stimulus process drives one operation
// per cycle and pushes the expected read-port / pwrap values computed by an
// arithmetic reference model; a monitor pops and compares on the falling edge.
module tb_regfile_pair;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  waddr = '0;
    logic [7:0]  wdata = '0;
    logic [2:0]  raddr_a = '0;
    logic [7:0]  rdata_a;
    logic [2:0]  raddr_b = '0;
    logic [7:0]  rdata_b;
    logic [1:0]  paddr = '0;
    logic        pwe = 1'b0;
    logic [15:0] pwdata = '0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic [15:0] prdata;
    logic        pwrap;

    regfile_pair #(.DATASIZE(8), .NREGS(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .paddr(paddr), .pwe(pwe), .pwdata(pwdata), .inc(inc), .dec(dec),
        .prdata(prdata), .pwrap(pwrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int p;
        int w;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state: plain integers, pair value formed arithmetically
    int mem [8];
    int mwrap = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (check %0d)", name, act, expv, checks);
        end
    endtask

    // monitor: compare whatever the DUT presents against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rdata_a", int'(rdata_a), e.a);
                chk("rdata_b", int'(rdata_b), e.b);
                chk("prdata",  int'(prdata),  e.p);
                chk("pwrap",   int'(pwrap),   e.w);
            end
        end
    end

    task automatic step(input logic r, input logic w, input int wa, input int wd,
                        input int ra, input int rb, input int pa, input logic pw,
                        input int pwd, input logic i, input logic d);
        int   nm [8];
        int   nwrap;
        int   p;
        int   np;
        bit   pairop;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; we = w; waddr = 3'(wa); wdata = 8'(wd);
        raddr_a = 3'(ra); raddr_b = 3'(rb); paddr = 2'(pa);
        pwe = pw; pwdata = 16'(pwd); inc = i; dec = d;
        if (r) begin
            for (int k = 0; k < 8; k++) mem[k] = 0;
            mwrap = 0;
        end
        // model of the next edge's effect
        for (int k = 0; k < 8; k++) nm[k] = mem[k];
        nwrap  = 0;
        pairop = 0;
        p  = mem[2*pa] * 256 + mem[2*pa+1];
        np = p;
        if (pw) begin
            np = pwd; pairop = 1;
        end else if (i && !d) begin
            np = (p + 1) % 65536; nwrap = (p == 65535); pairop = 1;
        end else if (d && !i) begin
            np = (p + 65535) % 65536; nwrap = (p == 0); pairop = 1;
        end
        nm[2*pa]   = np / 256;
        nm[2*pa+1] = np % 256;
        if (w && !(pairop && (wa / 2 == pa))) nm[wa] = wd;
        if (r) begin
            e.a = 0; e.b = 0; e.p = 0; e.w = 0;
        end else begin
`ifdef REGFILE_BYPASS_EN
            e.a = nm[ra]; e.b = nm[rb]; e.p = nm[2*pa] * 256 + nm[2*pa+1];
`else
            e.a = mem[ra]; e.b = mem[rb]; e.p = p;
`endif
            e.w = mwrap;
        end
        q.push_back(e);
        for (int k = 0; k < 8; k++) mem[k] = nm[k];
        mwrap = nwrap;
        if (r) begin
            @(negedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    task automatic idle(input int ra, input int rb, input int pa);
        step(0, 0, 0, 0, ra, rb, pa, 0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wa, pa, wd, pwd, sel;
        logic w, pw, i, d, r;
        for (int k = 0; k < 8; k++) mem[k] = 0;
        // reset, then byte write / read
        rst = 1'b1;
        #3;
        rst = 1'b0;
        idle(3, 0, 0);
        step(0, 1, 3, 8'h5A, 3, 0, 0, 0, 0, 0, 0);
        idle(3, 0, 0);
        // pair write then increment with carry into high byte
        step(0, 0, 0, 0, 4, 5, 2, 1, 16'h12FF, 0, 0);
        step(0, 0, 0, 0, 4, 5, 2, 0, 0, 1, 0);
        idle(4, 5, 2);
        // wrap both directions, then inc+dec together
        step(0, 0, 0, 0, 2, 3, 1, 1, 16'hFFFF, 0, 0);
        step(0, 0, 0, 0, 2, 3, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 2, 3, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 2, 3, 1, 0, 0, 1, 1);
        idle(2, 3, 1);
        idle(2, 3, 1);
        // priority clash, then non-clashing byte write
        step(0, 0, 0, 0, 0, 1, 0, 1, 16'h0010, 0, 0);
        step(0, 1, 1, 8'hAA, 1, 0, 0, 0, 0, 1, 0);
        step(0, 1, 6, 8'h77, 1, 6, 0, 0, 0, 1, 0);
        idle(1, 6, 0);
        // async reset in the middle of inc traffic
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        idle(0, 1, 0);
        // same-cycle byte write visibility (forwarded only with bypass)
        step(0, 1, 2, 8'h3C, 0, 2, 1, 0, 0, 0, 0);
        idle(0, 2, 1);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            w   = 1'($urandom_range(0, 1));
            wa  = int'($urandom_range(0, 7));
            wd  = int'($urandom_range(0, 255));
            pa  = int'($urandom_range(0, 3));
            pw  = ($urandom_range(0, 5) == 0);
            i   = ($urandom_range(0, 2) == 0);
            d   = ($urandom_range(0, 2) == 0);
            r   = ($urandom_range(0, 59) == 0);
            sel = int'($urandom_range(0, 2));
            pwd = (sel == 0) ? 16'hFFFF : (sel == 1) ? 0 : int'($urandom_range(0, 65535));
            // leave unspecified clash combinations out of the random mix
            if ((pw || (i && d)) && w && (wa / 2 == pa)) w = 1'b0;
            step(r, w, wa, wd, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 pa, pw, pwd, i, d);
        end
        idle(0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
